// File: rtl/time_hms_pkg.sv
// Shared types, mode encoding and BCD limits for the HH:MM:SS wall clock.
// Two-digit BCD fields are packed {tens, ones} so limits read naturally as 8'hNN.
package time_hms_pkg;

   typedef logic [3:0] bcd_t;

   typedef struct packed {
      bcd_t tens;
      bcd_t ones;
   } bcd2_t;

   typedef enum logic [1:0] {
      MODE_RUN     = 2'd0,
      MODE_SET_HR  = 2'd1,
      MODE_SET_MIN = 2'd2
   } mode_e;

   localparam bcd2_t SEC_MAX    = 8'h59;
   localparam bcd2_t MIN_MAX    = 8'h59;
   localparam bcd2_t HR_MAX_24  = 8'h23;
   localparam bcd2_t HR_MAX_12  = 8'h12;
   localparam bcd2_t HR_MIN_12  = 8'h01;
   localparam bcd2_t HR_PM_EDGE = 8'h11;
   localparam bcd2_t BCD2_ZERO  = 8'h00;

   // Digit-wise increment: ones wrap 9->0 and carry to tens, field wraps max->min.
   function automatic bcd2_t bcd2_inc(input bcd2_t v, input bcd2_t max_v, input bcd2_t min_v);
      bcd2_t r;
      if (v == max_v) begin
         r = min_v;
      end else if (v.ones == 4'd9) begin
         r.tens = v.tens + 4'd1;
         r.ones = 4'd0;
      end else begin
         r.tens = v.tens;
         r.ones = v.ones + 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/time_hms_counter_rise_detect.sv
// One-register rising-edge detector: pulse is high for the cycle in which d is
// high but was low at the previous clock edge.
module rise_detect (
   input  logic clk_50MHz,
   input  logic rst,
   input  logic d,
   output logic pulse
);

   logic d_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_50MHz) begin
      if (rst) begin
         d_q <= 1'b0;
      end else begin
         d_q <= d;
      end
   end

   assign pulse = d & ~d_q;

endmodule

// File: rtl/time_hms_counter.sv
// BCD HH:MM:SS clock advanced by the 1 Hz strobe, with a RUN/SET_HR/SET_MIN mode FSM.
// Define TIME_HMS_HOUR_12_EN for 12-hour format (01..12) with a PM flag.
module time_hms_counter
   import time_hms_pkg::*;
(
   input  logic       clk_50MHz,
   input  logic       rst,
   input  logic       sig_1s,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic [3:0] hr_tens,
   output logic [3:0] hr_ones,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic [1:0] mode,
   output logic       pm
);

`ifdef TIME_HMS_HOUR_12_EN
   localparam bit    HOUR_12  = 1'b1;
   localparam bcd2_t HR_MAX   = HR_MAX_12;
   localparam bcd2_t HR_MIN   = HR_MIN_12;
   localparam bcd2_t HR_RESET = HR_MAX_12;
`else
   localparam bit    HOUR_12  = 1'b0;
   localparam bcd2_t HR_MAX   = HR_MAX_24;
   localparam bcd2_t HR_MIN   = BCD2_ZERO;
   localparam bcd2_t HR_RESET = BCD2_ZERO;
`endif

   logic  tick;
   logic  mode_ev;
   logic  inc_ev;

   mode_e mode_q;
   bcd2_t sec_q, sec_d;
   bcd2_t min_q, min_d;
   bcd2_t hr_q,  hr_d;
   logic  pm_q,  pm_d;

   rise_detect u_tick_det (
      .clk_50MHz (clk_50MHz),
      .rst       (rst),
      .d         (sig_1s),
      .pulse     (tick)
   );

   rise_detect u_mode_det (
      .clk_50MHz (clk_50MHz),
      .rst       (rst),
      .d         (btn_mode),
      .pulse     (mode_ev)
   );

   rise_detect u_inc_det (
      .clk_50MHz (clk_50MHz),
      .rst       (rst),
      .d         (btn_inc),
      .pulse     (inc_ev)
   );

   always_ff @(posedge clk_50MHz) begin
      if (rst) begin
         mode_q <= MODE_RUN;
      end else begin
         case (mode_q)
            MODE_RUN:     if (mode_ev) mode_q <= MODE_SET_HR;
            MODE_SET_HR:  if (mode_ev) mode_q <= MODE_SET_MIN;
            MODE_SET_MIN: if (mode_ev) mode_q <= MODE_RUN;
            default:      mode_q <= MODE_RUN;
         endcase
      end
   end

   always_comb begin
      // NOTE: every next-state value gets a default first so no path through
      // the case leaves a signal unassigned and infers a latch.
      sec_d = sec_q;
      min_d = min_q;
      hr_d  = hr_q;
      pm_d  = pm_q;

      case (mode_q)
         MODE_RUN: begin
            // Leaving RUN clears seconds, and that clear wins over a same-cycle tick.
            if (mode_ev) begin
               sec_d = BCD2_ZERO;
            end else if (tick) begin
               sec_d = bcd2_inc(sec_q, SEC_MAX, BCD2_ZERO);
               if (sec_q == SEC_MAX) begin
                  min_d = bcd2_inc(min_q, MIN_MAX, BCD2_ZERO);
                  if (min_q == MIN_MAX) begin
                     hr_d = bcd2_inc(hr_q, HR_MAX, HR_MIN);
                     if (HOUR_12 && (hr_q == HR_PM_EDGE)) pm_d = ~pm_q;
                  end
               end
            end
         end
         MODE_SET_HR: begin
            sec_d = BCD2_ZERO;
            if (inc_ev && !mode_ev) begin
               hr_d = bcd2_inc(hr_q, HR_MAX, HR_MIN);
               if (HOUR_12 && (hr_q == HR_PM_EDGE)) pm_d = ~pm_q;
            end
         end
         MODE_SET_MIN: begin
            sec_d = BCD2_ZERO;
            if (inc_ev && !mode_ev) begin
               min_d = bcd2_inc(min_q, MIN_MAX, BCD2_ZERO);
            end
         end
         default: begin
            sec_d = sec_q;
         end
      endcase
   end

   always_ff @(posedge clk_50MHz) begin
      if (rst) begin
         sec_q <= BCD2_ZERO;
         min_q <= BCD2_ZERO;
         hr_q  <= HR_RESET;
         pm_q  <= 1'b0;
      end else begin
         sec_q <= sec_d;
         min_q <= min_d;
         hr_q  <= hr_d;
         pm_q  <= pm_d;
      end
   end

   assign hr_tens  = hr_q.tens;
   assign hr_ones  = hr_q.ones;
   assign min_tens = min_q.tens;
   assign min_ones = min_q.ones;
   assign sec_tens = sec_q.tens;
   assign sec_ones = sec_q.ones;
   assign mode     = mode_q;
   assign pm       = pm_q;

endmodule

// File: tb/tb_time_hms_counter.sv
// Directed bench for time_hms_counter; time is compared as a packed 24-bit
// BCD value 24'hHHMMSS. Build with TIME_HMS_HOUR_12_EN to run the 12-hour scenario.
module tb_time_hms_counter;

   logic       clk_50MHz;
   logic       rst;
   logic       sig_1s;
   logic       btn_mode;
   logic       btn_inc;
   logic [3:0] hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones;
   logic [1:0] mode;
   logic       pm;

   int checks = 0;
   int errors = 0;

   time_hms_counter dut (
      .clk_50MHz (clk_50MHz),
      .rst       (rst),
      .sig_1s    (sig_1s),
      .btn_mode  (btn_mode),
      .btn_inc   (btn_inc),
      .hr_tens   (hr_tens),
      .hr_ones   (hr_ones),
      .min_tens  (min_tens),
      .min_ones  (min_ones),
      .sec_tens  (sec_tens),
      .sec_ones  (sec_ones),
      .mode      (mode),
      .pm        (pm)
   );

   initial clk_50MHz = 1'b0;
   always #10 clk_50MHz = ~clk_50MHz;

   function automatic logic [23:0] now_t();
      return {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};
   endfunction

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step(input int n);
      repeat (n) @(negedge clk_50MHz);
   endtask

   task automatic pulse_sec(input int n);
      repeat (n) begin
         sig_1s = 1'b1;
         step(1);
         sig_1s = 1'b0;
         step(1);
      end
   endtask

   task automatic press_mode();
      btn_mode = 1'b1;
      step(1);
      btn_mode = 1'b0;
      step(1);
   endtask

   task automatic press_inc(input int n);
      repeat (n) begin
         btn_inc = 1'b1;
         step(1);
         btn_inc = 1'b0;
         step(1);
      end
   endtask

   task automatic test_reset(input logic [23:0] exp_t);
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(1);
      checks++;
      if (now_t() !== exp_t) begin
         errors++;
         $display("FAIL reset_time: got %h expected %h", now_t(), exp_t);
      end
      checks++;
      if (mode !== 2'd0) begin
         errors++;
         $display("FAIL reset_mode: got %0d expected 0", mode);
      end
      checks++;
      if (pm !== 1'b0) begin
         errors++;
         $display("FAIL reset_pm: got %0d expected 0", pm);
      end
   endtask

`ifndef TIME_HMS_HOUR_12_EN
   task automatic test_count();
      pulse_sec(3);
      checks++;
      if (now_t() !== 24'h000003) begin
         errors++;
         $display("FAIL count_3: got %h expected 000003", now_t());
      end
      checks++;
      if (mode !== 2'd0) begin
         errors++;
         $display("FAIL count_mode: got %0d expected 0", mode);
      end
   endtask

   task automatic test_pulse_width();
      sig_1s = 1'b1;
      step(1);
      checks++;
      if (now_t() !== 24'h000004) begin
         errors++;
         $display("FAIL latency_one_edge: got %h expected 000004", now_t());
      end
      step(9);
      checks++;
      if (now_t() !== 24'h000004) begin
         errors++;
         $display("FAIL wide_pulse_once: got %h expected 000004", now_t());
      end
      sig_1s = 1'b0;
      step(1);
   endtask

   task automatic test_set_mode();
      pulse_sec(13);
      checks++;
      if (now_t() !== 24'h000017) begin
         errors++;
         $display("FAIL set_start: got %h expected 000017", now_t());
      end
      press_mode();
      checks++;
      if (mode !== 2'd1 || now_t() !== 24'h000000) begin
         errors++;
         $display("FAIL enter_set_hr: got mode %0d time %h expected mode 1 time 000000", mode, now_t());
      end
      press_inc(25);
      pulse_sec(1);
      checks++;
      if (now_t() !== 24'h010000) begin
         errors++;
         $display("FAIL set_hr_wrap: got %h expected 010000", now_t());
      end
      press_mode();
      checks++;
      if (mode !== 2'd2) begin
         errors++;
         $display("FAIL enter_set_min: got %0d expected 2", mode);
      end
      press_inc(61);
      pulse_sec(1);
      checks++;
      if (now_t() !== 24'h010100) begin
         errors++;
         $display("FAIL set_min_wrap: got %h expected 010100", now_t());
      end
      press_mode();
      checks++;
      if (mode !== 2'd0 || now_t() !== 24'h010100) begin
         errors++;
         $display("FAIL set_exit: got mode %0d time %h expected mode 0 time 010100", mode, now_t());
      end
   endtask

   task automatic test_rollover();
      press_mode();
      press_inc(22);
      press_mode();
      press_inc(58);
      press_mode();
      checks++;
      if (now_t() !== 24'h235900) begin
         errors++;
         $display("FAIL preload: got %h expected 235900", now_t());
      end
      pulse_sec(59);
      checks++;
      if (now_t() !== 24'h235959) begin
         errors++;
         $display("FAIL pre_rollover: got %h expected 235959", now_t());
      end
      sig_1s = 1'b1;
      step(1);
      checks++;
      if (now_t() !== 24'h000000) begin
         errors++;
         $display("FAIL rollover: got %h expected 000000", now_t());
      end
      sig_1s = 1'b0;
      step(1);
      pulse_sec(60);
      checks++;
      if (now_t() !== 24'h000100) begin
         errors++;
         $display("FAIL minute_carry: got %h expected 000100", now_t());
      end
   endtask

   task automatic test_simultaneous();
      btn_mode = 1'b1;
      btn_inc  = 1'b1;
      step(1);
      checks++;
      if (mode !== 2'd1 || now_t() !== 24'h000100) begin
         errors++;
         $display("FAIL mode_inc_run: got mode %0d time %h expected mode 1 time 000100", mode, now_t());
      end
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      step(1);
      btn_mode = 1'b1;
      btn_inc  = 1'b1;
      step(1);
      checks++;
      if (mode !== 2'd2 || now_t() !== 24'h000100) begin
         errors++;
         $display("FAIL mode_inc_set_hr: got mode %0d time %h expected mode 2 time 000100", mode, now_t());
      end
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      step(1);
      press_mode();
      pulse_sec(5);
      checks++;
      if (now_t() !== 24'h000105) begin
         errors++;
         $display("FAIL resume_run: got %h expected 000105", now_t());
      end
      sig_1s   = 1'b1;
      btn_mode = 1'b1;
      step(1);
      checks++;
      if (mode !== 2'd1 || now_t() !== 24'h000100) begin
         errors++;
         $display("FAIL tick_mode: got mode %0d time %h expected mode 1 time 000100", mode, now_t());
      end
      sig_1s   = 1'b0;
      btn_mode = 1'b0;
      step(1);
      press_mode();
      press_mode();
      checks++;
      if (mode !== 2'd0) begin
         errors++;
         $display("FAIL back_to_run: got %0d expected 0", mode);
      end
   endtask

   task automatic test_reset_mid();
      press_mode();
      press_mode();
      press_inc(3);
      checks++;
      if (mode !== 2'd2 || now_t() !== 24'h000400) begin
         errors++;
         $display("FAIL pre_reset: got mode %0d time %h expected mode 2 time 000400", mode, now_t());
      end
      rst     = 1'b1;
      sig_1s  = 1'b1;
      btn_inc = 1'b1;
      step(1);
      checks++;
      if (mode !== 2'd0 || now_t() !== 24'h000000) begin
         errors++;
         $display("FAIL reset_mid: got mode %0d time %h expected mode 0 time 000000", mode, now_t());
      end
      rst = 1'b0;
      step(1);
      checks++;
      if (mode !== 2'd0 || now_t() !== 24'h000001) begin
         errors++;
         $display("FAIL tick_after_reset: got mode %0d time %h expected mode 0 time 000001", mode, now_t());
      end
      sig_1s  = 1'b0;
      btn_inc = 1'b0;
      step(1);
   endtask
`else
   task automatic test_hour_12();
      press_mode();
      press_inc(11);
      checks++;
      if (now_t() !== 24'h110000 || pm !== 1'b0) begin
         errors++;
         $display("FAIL set_hr_11: got %h pm %0d expected 110000 pm 0", now_t(), pm);
      end
      press_inc(1);
      checks++;
      if (now_t() !== 24'h120000 || pm !== 1'b1) begin
         errors++;
         $display("FAIL set_hr_11_12: got %h pm %0d expected 120000 pm 1", now_t(), pm);
      end
      press_inc(1);
      checks++;
      if (now_t() !== 24'h010000 || pm !== 1'b1) begin
         errors++;
         $display("FAIL set_hr_12_01: got %h pm %0d expected 010000 pm 1", now_t(), pm);
      end
      press_inc(11);
      press_inc(11);
      checks++;
      if (now_t() !== 24'h110000 || pm !== 1'b0) begin
         errors++;
         $display("FAIL set_hr_back_11: got %h pm %0d expected 110000 pm 0", now_t(), pm);
      end
      press_mode();
      press_inc(59);
      press_mode();
      pulse_sec(59);
      checks++;
      if (now_t() !== 24'h115959 || mode !== 2'd0) begin
         errors++;
         $display("FAIL run_115959: got %h mode %0d expected 115959 mode 0", now_t(), mode);
      end
      pulse_sec(1);
      checks++;
      if (now_t() !== 24'h120000 || pm !== 1'b1) begin
         errors++;
         $display("FAIL run_noon: got %h pm %0d expected 120000 pm 1", now_t(), pm);
      end
      press_mode();
      press_mode();
      press_inc(59);
      press_mode();
      pulse_sec(59);
      pulse_sec(1);
      checks++;
      if (now_t() !== 24'h010000 || pm !== 1'b1) begin
         errors++;
         $display("FAIL run_12_01: got %h pm %0d expected 010000 pm 1", now_t(), pm);
      end
   endtask
`endif

   initial begin
      rst      = 1'b1;
      sig_1s   = 1'b0;
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      step(1);
`ifndef TIME_HMS_HOUR_12_EN
      test_reset(24'h000000);
      test_count();
      test_pulse_width();
      test_set_mode();
      test_rollover();
      test_simultaneous();
      test_reset_mid();
`else
      test_reset(24'h120000);
      test_hour_12();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
